// File: rtl/uart_host_ctrl_pkg.sv
// uart_host_ctrl_pkg: shared state encodings and frame sizing for the host-link controller
// Provides the tx framer states, the load/run phase encoding and the bytes-per-sample helper.
package uart_host_ctrl_pkg;
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_PUSH = 2'd1;
  localparam logic [1:0] TX_WAIT = 2'd2;
  localparam logic LOAD = 1'b0;
  localparam logic RUN  = 1'b1;
  function automatic int calc_nb(input int dw);
    return (dw + 7) / 8;
  endfunction
endpackage

// File: rtl/uart_sample_framer.sv
// uart_sample_framer: captures synth samples on a rising sample edge and streams them as UART bytes
// Ports: clk/rst clock and async active-high reset; i_sample/i_left/i_right sample input;
//        o_tx_data/o_tx_wr/i_tx_done transmitter handshake; o_drop_cnt saturating dropped-sample count.
module uart_sample_framer
  import uart_host_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int STEREO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sample,
  input  logic [DW-1:0] i_left,
  input  logic [DW-1:0] i_right,
  input  logic          i_tx_done,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_wr,
  output logic [7:0]    o_drop_cnt
);
  localparam int NB = calc_nb(DW);
  localparam int FB = NB * (STEREO + 1);
  localparam int CW = $clog2(FB) + 1;
  logic            r_sample_d;
  logic [1:0]      r_state;
  logic [CW-1:0]   r_rem;
  logic [8*FB-1:0] r_buf;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_drop;
  logic [8*FB-1:0] w_frame;
  logic [8*FB-1:0] w_next;
  logic            w_rise;
  assign w_rise     = i_sample & ~r_sample_d;
  assign w_next     = r_buf >> 8;
  assign o_tx_wr    = r_state == TX_PUSH;
  assign o_tx_data  = r_tx_data;
  assign o_drop_cnt = r_drop;
  // Channels are sign-extended to whole bytes; left occupies the low bytes so it is sent first.
  generate
    if (STEREO != 0) begin : g_stereo
      assign w_frame = {(8*NB)'($signed(i_right)), (8*NB)'($signed(i_left))};
    end else begin : g_mono
      logic signed [DW:0] w_sum;
      assign w_sum = {i_left[DW-1], i_left} + {i_right[DW-1], i_right};
      // After the arithmetic shift bit DW equals bit DW-1, so extending from DW+1 bits
      // matches truncating to DW bits and sign-extending.
      assign w_frame = (8*NB)'(w_sum >>> 1);
    end
  endgenerate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_d <= 1'b0;
      r_state    <= TX_IDLE;
      r_rem      <= '0;
      r_buf      <= '0;
      r_tx_data  <= '0;
      r_drop     <= '0;
    end else begin
      r_sample_d <= i_sample;
      if (w_rise && r_state != TX_IDLE && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (r_state == TX_IDLE) begin
        if (w_rise) begin
          r_buf     <= w_frame;
          r_tx_data <= w_frame[7:0];
          r_rem     <= CW'(FB - 1);
          r_state   <= TX_PUSH;
        end
      end else if (r_state == TX_PUSH) begin
        r_state <= TX_WAIT;
      end else if (i_tx_done) begin
        if (r_rem == '0) begin
          r_state <= TX_IDLE;
        end else begin
          r_buf     <= w_next;
          r_tx_data <= w_next[7:0];
          r_rem     <= r_rem - 1'b1;
          r_state   <= TX_PUSH;
        end
      end
    end
  end
endmodule

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: host-link controller loading the sound ROM, forwarding commands and streaming samples
// Ports: clk/rst clock and async active-high reset; i_rx_* UART receive byte stream;
//        o_tx_data/o_tx_wr/i_tx_done UART transmit handshake; i_sample/i_left/i_right synth output;
//        o_sound_latch/o_irq/i_clear_irq CPU command handshake; o_cpu_rst CPU reset;
//        o_rom_wr/o_rom_addr/o_rom_din ROM write port; o_loading load phase flag;
//        o_overrun sticky lost-command flag; o_drop_cnt dropped-sample count.
module uart_host_ctrl
  import uart_host_ctrl_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 16,
  parameter int STEREO = 0,
  parameter int FAST_LOAD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  input  logic          i_rx_error,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_wr,
  input  logic          i_tx_done,
  input  logic          i_sample,
  input  logic [DW-1:0] i_left,
  input  logic [DW-1:0] i_right,
  output logic [7:0]    o_sound_latch,
  output logic          o_irq,
  input  logic          i_clear_irq,
  output logic          o_cpu_rst,
  output logic          o_rom_wr,
  output logic [AW-1:0] o_rom_addr,
  output logic [7:0]    o_rom_din,
  output logic          o_loading,
  output logic          o_overrun,
  output logic [7:0]    o_drop_cnt
);
  localparam logic [AW-1:0] START = FAST_LOAD != 0 ? AW'(2**AW - 16) : '0;
  logic          r_state;
  logic          r_cpu_rst;
  logic          r_rom_wr;
  logic [AW-1:0] r_rom_addr;
  logic [7:0]    r_rom_din;
  logic [7:0]    r_latch;
  logic          r_irq;
  logic          r_overrun;
  logic          w_acc;
  logic          w_load;
  logic          w_last;
  logic          w_cmd;
  logic          w_rom_acc;
  assign w_acc  = i_rx_valid & ~i_rx_error;
  assign w_load = r_state == LOAD;
  // Strobe for the final ROM byte: the phase switches to RUN as it completes.
  assign w_last = r_rom_wr & (&r_rom_addr);
  // A byte arriving during the final strobe has no address left to go to, so it is not written.
  assign w_rom_acc = w_acc & w_load & ~w_last;
  assign w_cmd  = w_acc & ~w_load;
  assign o_loading     = w_load;
  assign o_cpu_rst     = r_cpu_rst;
  assign o_rom_wr      = r_rom_wr;
  assign o_rom_addr    = r_rom_addr;
  assign o_rom_din     = r_rom_din;
  assign o_sound_latch = r_latch;
  assign o_irq         = r_irq;
  assign o_overrun     = r_overrun;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_cpu_rst  <= 1'b1;
      r_rom_wr   <= 1'b0;
      r_rom_addr <= START;
      r_rom_din  <= '0;
      r_latch    <= '0;
      r_irq      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_cpu_rst <= w_load;
      r_rom_wr  <= w_rom_acc;
      if (w_rom_acc) r_rom_din <= i_rx_data;
      if (r_rom_wr) r_rom_addr <= r_rom_addr + 1'b1;
      if (w_last) r_state <= RUN;
      if (w_cmd) r_latch <= i_rx_data;
      // A new command outranks a coincident acknowledge; irq never rises during load.
      r_irq     <= w_cmd | (r_irq & ~i_clear_irq);
      r_overrun <= r_overrun | (w_cmd & r_irq & ~i_clear_irq);
    end
  end
  uart_sample_framer #(
    .DW(DW),
    .STEREO(STEREO)
  ) u_framer (
    .clk(clk),
    .rst(rst),
    .i_sample(i_sample),
    .i_left(i_left),
    .i_right(i_right),
    .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data),
    .o_tx_wr(o_tx_wr),
    .o_drop_cnt(o_drop_cnt)
  );
endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: randomized bench checking a mono and a stereo controller against a behavioural model
`timescale 1ns/1ps
module tb_uart_host_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_error = 1'b0, clear_irq = 1'b0;
  logic sample [2];
  logic [DW-1:0] left [2];
  logic [DW-1:0] right [2];
  logic tx_done [2];
  logic [7:0] tx_data [2];
  logic tx_wr [2];
  logic [7:0] drop_cnt [2];
  logic [7:0] latch [2];
  logic irq [2], cpu_rst [2], rom_wr [2], loading [2], overrun [2];
  logic [AW-1:0] rom_addr [2];
  logic [7:0] rom_din [2];
  uart_host_ctrl #(.AW(AW), .DW(DW), .STEREO(0), .FAST_LOAD(0)) u_mono (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
    .o_tx_data(tx_data[0]), .o_tx_wr(tx_wr[0]), .i_tx_done(tx_done[0]), .i_sample(sample[0]),
    .i_left(left[0]), .i_right(right[0]), .o_sound_latch(latch[0]), .o_irq(irq[0]),
    .i_clear_irq(clear_irq), .o_cpu_rst(cpu_rst[0]), .o_rom_wr(rom_wr[0]), .o_rom_addr(rom_addr[0]),
    .o_rom_din(rom_din[0]), .o_loading(loading[0]), .o_overrun(overrun[0]), .o_drop_cnt(drop_cnt[0]));
  uart_host_ctrl #(.AW(AW), .DW(DW), .STEREO(1), .FAST_LOAD(0)) u_stereo (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
    .o_tx_data(tx_data[1]), .o_tx_wr(tx_wr[1]), .i_tx_done(tx_done[1]), .i_sample(sample[1]),
    .i_left(left[1]), .i_right(right[1]), .o_sound_latch(latch[1]), .o_irq(irq[1]),
    .i_clear_irq(clear_irq), .o_cpu_rst(cpu_rst[1]), .o_rom_wr(rom_wr[1]), .o_rom_addr(rom_addr[1]),
    .o_rom_din(rom_din[1]), .o_loading(loading[1]), .o_overrun(overrun[1]), .o_drop_cnt(drop_cnt[1]));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // Model: ROM progress as a count of bytes written, command state as plain flags,
  // and each in-flight frame as a list of bytes still owed to the host.
  int m_written;
  bit m_wr, m_cpu_rst, m_irq, m_ovr;
  logic [7:0] m_din, m_latch;
  bit m_prev [2], m_busy [2], m_push [2], m_wait [2];
  logic [7:0] m_tx [2];
  logic [7:0] m_fr [2][4];
  int m_idx [2], m_len [2], m_drop [2];
  function automatic void model_reset();
    m_written = 0; m_wr = 0; m_cpu_rst = 1; m_irq = 0; m_ovr = 0; m_din = '0; m_latch = '0;
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 0; m_busy[k] = 0; m_push[k] = 0; m_wait[k] = 0; m_tx[k] = '0;
      m_idx[k] = 0; m_len[k] = 0; m_drop[k] = 0;
    end
  endfunction
  function automatic void build_frame(input int k);
    int l, r, m;
    l = $signed(left[k]);
    r = $signed(right[k]);
    if (k == 0) begin
      m = (l + r) >>> 1;
      m_fr[k][0] = m[7:0]; m_fr[k][1] = m[15:8]; m_len[k] = 2;
    end else begin
      m_fr[k][0] = l[7:0]; m_fr[k][1] = l[15:8]; m_fr[k][2] = r[7:0]; m_fr[k][3] = r[15:8];
      m_len[k] = 4;
    end
  endfunction
  initial model_reset();
  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      bit acc, was_load, rise, was_push, was_wait, busy;
      acc = rx_valid && !rx_error;
      was_load = m_written < 16;
      m_cpu_rst = was_load;
      if (m_wr) m_written++;
      m_wr = acc && was_load;
      if (m_wr) m_din = rx_data;
      if (acc && !was_load) begin
        if (m_irq && !clear_irq) m_ovr = 1;
        m_latch = rx_data;
        m_irq = 1;
      end else if (clear_irq) m_irq = 0;
      for (int k = 0; k < 2; k++) begin
        rise = sample[k] && !m_prev[k];
        m_prev[k] = sample[k];
        was_push = m_push[k]; was_wait = m_wait[k]; busy = m_busy[k];
        m_push[k] = 0;
        if (was_push) m_wait[k] = 1;
        if (was_wait && tx_done[k]) begin
          m_wait[k] = 0;
          if (m_idx[k] < m_len[k]) begin
            m_tx[k] = m_fr[k][m_idx[k]]; m_idx[k]++; m_push[k] = 1;
          end else m_busy[k] = 0;
        end
        if (rise) begin
          if (busy) begin
            if (m_drop[k] < 255) m_drop[k]++;
          end else begin
            build_frame(k);
            m_busy[k] = 1; m_tx[k] = m_fr[k][0]; m_idx[k] = 1; m_push[k] = 1;
          end
        end
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rom_wr%0d", k), rom_wr[k], m_wr);
      if (m_wr) chk($sformatf("rom_din%0d", k), rom_din[k], m_din);
      chk($sformatf("rom_addr%0d", k), rom_addr[k], m_written % 16);
      chk($sformatf("loading%0d", k), loading[k], m_written < 16);
      chk($sformatf("cpu_rst%0d", k), cpu_rst[k], m_cpu_rst);
      chk($sformatf("latch%0d", k), latch[k], m_latch);
      chk($sformatf("irq%0d", k), irq[k], m_irq);
      chk($sformatf("overrun%0d", k), overrun[k], m_ovr);
      chk($sformatf("tx_wr%0d", k), tx_wr[k], m_push[k]);
      chk($sformatf("tx_data%0d", k), tx_data[k], m_tx[k]);
      chk($sformatf("drop%0d", k), drop_cnt[k], m_drop[k]);
    end
  end
  // Recorders for the literal expectations below.
  logic [7:0] rec0 [$], rec1 [$];
  logic [7:0] seen [16];
  int wrcnt = 0;
  int cyc = 0, t_load = 0, t_cpu = 0;
  bit p_load = 1, p_cpu = 1;
  always @(negedge clk) begin
    cyc++;
    if (!rst && tx_wr[0]) rec0.push_back(tx_data[0]);
    if (!rst && tx_wr[1]) rec1.push_back(tx_data[1]);
    if (!rst && rom_wr[0]) begin seen[rom_addr[0]] = rom_din[0]; wrcnt++; end
    if (p_load && !loading[0]) t_load = cyc;
    if (p_cpu && !cpu_rst[0]) t_cpu = cyc;
    p_load = loading[0];
    p_cpu = cpu_rst[0];
  end
  task automatic responder(input int k);
    forever begin
      @(negedge clk);
      tx_done[k] = 1'b0;
      if (tx_wr[k]) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        tx_done[k] = 1'b1;
      end
    end
  endtask
  initial responder(0);
  initial responder(1);
  task automatic send(input logic [7:0] b, input bit err, input bit clr);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_error = err; clear_irq = clr;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0; clear_irq = 1'b0;
  endtask
  task automatic load_rom(input bit with_err);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0);
      @(negedge clk);
      if (with_err && i == 5) begin
        send(8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        chk("err_byte_addr", rom_addr[0], 6);
        chk("err_byte_wrcnt", wrcnt, 6);
      end
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_bytes(input int k, input int n);
    int t = 0;
    while ((k == 0 ? rec0.size() : rec1.size()) < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("frame%0d_len", k), k == 0 ? rec0.size() : rec1.size(), n);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      sample[k] = 1'b0; left[k] = '0; right[k] = '0; tx_done[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_loading", loading[0], 1);
    chk("rst_cpu_rst", cpu_rst[1], 1);
    chk("rst_rom_addr", rom_addr[0], 0);
    chk("rst_irq", irq[0], 0);
    chk("rst_tx_wr", tx_wr[1], 0);
    #2 rst = 1'b0;
    load_rom(1'b1);
    chk("load_wrcnt", wrcnt, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("rom_byte%0d", i), seen[i], i);
    chk("load_done_loading", loading[0], 0);
    chk("load_done_cpu_rst", cpu_rst[0], 0);
    chk("load_done_addr", rom_addr[1], 0);
    chk("cpu_rst_lag", t_cpu - t_load, 1);
    send(8'h5C, 1'b0, 1'b0);
    chk("cmd1_latch", latch[0], 8'h5C);
    chk("cmd1_irq", irq[0], 1);
    send(8'h33, 1'b0, 1'b0);
    chk("cmd2_latch", latch[1], 8'h33);
    chk("cmd2_overrun", overrun[0], 1);
    @(negedge clk); clear_irq = 1'b1;
    @(negedge clk); clear_irq = 1'b0;
    chk("clear_irq", irq[0], 0);
    chk("clear_overrun_sticky", overrun[0], 1);
    rec0.delete();
    @(negedge clk); left[0] = 16'h8000; right[0] = 16'hFFFE; sample[0] = 1'b1;
    @(negedge clk); sample[0] = 1'b0; left[0] = 16'h1111;
    wait_bytes(0, 2);
    repeat (10) @(negedge clk);
    chk("mono_b0", rec0[0], 8'hFF);
    chk("mono_b1", rec0[1], 8'hBF);
    rec1.delete();
    @(negedge clk); left[1] = 16'h1234; right[1] = 16'hABCD; sample[1] = 1'b1;
    @(negedge clk); sample[1] = 1'b0;
    wait_bytes(1, 1);
    @(negedge clk); left[1] = 16'hFFFF; right[1] = 16'hFFFF; sample[1] = 1'b1;
    @(negedge clk); sample[1] = 1'b0;
    wait_bytes(1, 4);
    repeat (10) @(negedge clk);
    chk("st_b0", rec1[0], 8'h34);
    chk("st_b1", rec1[1], 8'h12);
    chk("st_b2", rec1[2], 8'hCD);
    chk("st_b3", rec1[3], 8'hAB);
    chk("st_drop", drop_cnt[1], 1);
    rec1.delete();
    @(negedge clk); left[1] = 16'h5A5A; sample[1] = 1'b1; sample[0] = 1'b1;
    @(negedge clk); sample[1] = 1'b0; sample[0] = 1'b0;
    wait_bytes(1, 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_wr", tx_wr[1], 0);
    chk("arst_loading", loading[1], 1);
    chk("arst_cpu_rst", cpu_rst[0], 1);
    chk("arst_drop", drop_cnt[1], 0);
    chk("arst_overrun", overrun[0], 0);
    chk("arst_latch", latch[1], 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_abandoned", rec1.size(), 2);
    wrcnt = 0;
    load_rom(1'b0);
    chk("reload_wrcnt", wrcnt, 16);
    send(8'h21, 1'b0, 1'b0);
    chk("coll_pre_irq", irq[0], 1);
    send(8'h10, 1'b0, 1'b1);
    chk("coll_irq", irq[0], 1);
    chk("coll_latch", latch[0], 8'h10);
    chk("coll_overrun", overrun[1], 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rx_valid = $urandom_range(0, 3) == 0;
      rx_error = rx_valid && $urandom_range(0, 4) == 0;
      rx_data = 8'($urandom);
      clear_irq = $urandom_range(0, 5) == 0;
      for (int k = 0; k < 2; k++) begin
        left[k] = DW'($urandom);
        right[k] = DW'($urandom);
        if ($urandom_range(0, 9) == 0) sample[k] = ~sample[k];
      end
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0; clear_irq = 1'b0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
Parametrised host-link controller for the FPGA sound-chip test harness. It sits between a byte-level UART transceiver and the sound CPU/synth core. After reset it loads the program ROM from the serial stream. It then forwards host bytes to the CPU as sound commands with an IRQ handshake, and streams synth output samples back to the host in mono or stereo framing.

Parameters:
AW, 15, ROM address width; load phase writes exactly 2**AW bytes
DW, 16, synth sample width in bits, signed, 8..32
STEREO, 0, 0 = send mono average per sample, 1 = send left then right
FAST_LOAD, 0, 1 = load start address 2**AW-16 (simulation only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_error  in  1  framing error qualifier for rx_valid
tx_data  out  8  byte to UART transmitter
tx_wr  out  1  one-cycle transmit request
tx_done  in  1  one-cycle strobe, transmitter finished a byte
sample  in  1  synth sample-ready level; rising edge captures data
left  in  DW  left channel, signed
right  in  DW  right channel, signed
sound_latch  out  8  last command byte for the CPU
irq  out  1  CPU interrupt request
clear_irq  in  1  CPU acknowledge, clears irq
cpu_rst  out  1  CPU reset, held during ROM load
rom_wr  out  1  one-cycle ROM write strobe
rom_addr  out  AW  ROM write address
rom_din  out  8  ROM write data
loading  out  1  high while in the load phase
overrun  out  1  sticky: command arrived while irq was still set
drop_cnt  out  8  saturating count of samples dropped while tx was busy

Behaviour:
- Reset values: all outputs 0, except cpu_rst=1 and loading=1. rom_addr=0, or 2**AW-16 when FAST_LOAD=1.
- A received byte is accepted only on rx_valid && !rx_error. Errored bytes are ignored in both phases.
- Load FSM states:
  - LOAD: each accepted byte gives, on the next cycle, rom_wr=1 for one cycle with rom_din=byte at the current rom_addr. rom_addr increments the cycle after the strobe.
  - When the byte at address 2**AW-1 is written, rom_addr wraps to 0 and the FSM moves to RUN.
  - RUN: loading=0, and cpu_rst deasserts one cycle after entering RUN. The controller never returns to LOAD except by rst.
- Command path (RUN only): an accepted byte sets sound_latch=byte and irq=1 on the next cycle. If irq was already 1 at that moment, overrun is set and stays set (sticky), and the latch is overwritten.
- clear_irq clears irq on the next cycle. If clear_irq and an accepted byte coincide, the set wins: irq stays 1 and overrun is not set.
- clear_irq is ignored in the LOAD phase.
- Sample capture:
  - sample is edge-detected with one internal register. Capture happens on the cycle the rising edge is seen, in both phases.
  - Mono word = (left + right) computed at DW+1 bits, then arithmetically shifted right by 1 and truncated to DW bits.
  - Stereo captures left and right unchanged.
- Tx FSM states: TX_IDLE, TX_PUSH, TX_WAIT.
  - Frame length = NB*(STEREO+1) bytes, where NB = ceil(DW/8). Bytes are sent LSB first; in stereo, left precedes right. The top byte is sign-extended when DW is not a multiple of 8.
  - TX_PUSH drives tx_wr=1 for exactly one cycle with the byte, then moves to TX_WAIT.
  - TX_WAIT moves on tx_done: to TX_PUSH for the next byte, or to TX_IDLE after the last byte.
  - tx_data holds its value until the next push.
  - A rising sample edge while not in TX_IDLE drops that sample: drop_cnt increments, saturating at 255. The in-flight frame is never corrupted.
- Rx and tx paths are independent and may be active in the same cycle.
- Asynchronous rst mid-load, mid-frame or mid-handshake returns everything to its reset values immediately. A partial frame is abandoned without tx_wr.

Decomposition:
- Shared package: tx state encoding, load state encoding (LOAD, RUN), and the function computing NB from DW.
- Natural sub-module: uart_sample_framer, holding the capture, mono arithmetic, tx FSM and drop counter. The top keeps the load FSM and the command/IRQ logic.

Test Plan:
- Load, AW=4: 16 bytes 0x00..0x0F, one strobe each → 16 rom_wr pulses at addr 0..15 with matching data; loading falls, cpu_rst falls one cycle later, rom_addr=0.
- rx_error during load: byte 0xAA with rx_error=1 → no rom_wr, rom_addr unchanged.
- Command, RUN: byte 0x5C → sound_latch=0x5C, irq=1.
  - Second byte 0x33 before clear_irq → sound_latch=0x33, overrun=1.
  - clear_irq pulse → irq=0; overrun stays 1.
- Set/clear collision: clear_irq coincident with accepted byte 0x10 → irq stays 1, overrun unchanged.
- Mono, DW=16: left=0x8000, right=0xFFFE → word 0xBFFF; tx bytes 0xFF then 0xBF, one tx_wr each, each sent only after the previous tx_done.
- Stereo with drop, STEREO=1: left=0x1234, right=0xABCD → bytes 34,12,CD,AB; a second sample edge mid-frame → drop_cnt=1 and the frame completes intact.
